// File: rtl/fabric_config_loader.sv
// fabric_config_loader: streams host bitstream words serially into a tile config chain,
// commits them with a single set strobe and reads the previous chain contents back from the tail.
`default_nettype none

module fabric_config_loader #(
  parameter int WORD_W    = 32,
  parameter int CHAIN_LEN = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              word_valid,
  input  logic [WORD_W-1:0] word_data,
  output logic              word_ready,
  output logic              cfg_shift,
  output logic              cfg_cen,
  output logic              cfg_set,
  input  logic              cfg_tail,
  output logic              busy,
  output logic              done,
  output logic              rb_valid,
  output logic [WORD_W-1:0] rb_data
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int WB_W  = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(CHAIN_LEN - 1);
  localparam logic [WB_W-1:0]  LAST_WBIT = WB_W'(WORD_W - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_SHIFT = 3'd2,
    S_SET   = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [WB_W-1:0]    wbit_q, wbit_d;
  logic [WB_W-1:0]    rb_cnt_q, rb_cnt_d;
  logic [WORD_W-1:0]  word_sr_q, word_sr_d;
  logic [WORD_W-1:0]  rb_sr_q, rb_sr_d;
  logic [WORD_W-1:0]  rb_data_q, rb_data_d;
  logic [WORD_W-1:0]  rb_merged;
  logic               rb_valid_q, rb_valid_d;
  logic               cfg_shift_q, cfg_shift_d;
  logic               cfg_cen_q, cfg_cen_d;
  logic               cfg_set_q, cfg_set_d;
  logic               word_ready_q, word_ready_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    wbit_d      = wbit_q;
    rb_cnt_d    = rb_cnt_q;
    word_sr_d   = word_sr_q;
    rb_sr_d     = rb_sr_q;
    rb_data_d   = rb_data_q;
    rb_valid_d  = 1'b0;
    cfg_shift_d = cfg_shift_q;
    rb_merged   = rb_sr_q | (WORD_W'(cfg_tail) << rb_cnt_q);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_FETCH;
          bit_cnt_d = '0;
          rb_cnt_d  = '0;
          rb_sr_d   = '0;
        end
      end
      S_FETCH: begin
        if (word_valid) begin
          state_d     = S_SHIFT;
          cfg_shift_d = word_data[0];
          word_sr_d   = word_data >> 1;
          wbit_d      = '0;
        end
      end
      S_SHIFT: begin
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
        // The last chain bit flushes whatever readback has been gathered so far.
        if (rb_cnt_q == LAST_WBIT || bit_cnt_q == LAST_BIT) begin
          rb_data_d  = rb_merged;
          rb_valid_d = 1'b1;
          rb_sr_d    = '0;
          rb_cnt_d   = '0;
        end else begin
          rb_sr_d  = rb_merged;
          rb_cnt_d = rb_cnt_q + WB_W'(1);
        end
        if (bit_cnt_q == LAST_BIT) begin
          state_d = S_SET;
        end else if (wbit_q == LAST_WBIT) begin
          state_d = S_FETCH;
        end else begin
          cfg_shift_d = word_sr_q[0];
          word_sr_d   = word_sr_q >> 1;
          wbit_d      = wbit_q + WB_W'(1);
        end
      end
      S_SET:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Strobes are registered copies of the upcoming state so they align with it.
    word_ready_d = (state_d == S_FETCH);
    cfg_cen_d    = (state_d == S_SHIFT);
    cfg_set_d    = (state_d == S_SET);
    busy_d       = (state_d != S_IDLE);
    done_d       = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      bit_cnt_q    <= '0;
      wbit_q       <= '0;
      rb_cnt_q     <= '0;
      word_sr_q    <= '0;
      rb_sr_q      <= '0;
      rb_data_q    <= '0;
      rb_valid_q   <= 1'b0;
      cfg_shift_q  <= 1'b0;
      cfg_cen_q    <= 1'b0;
      cfg_set_q    <= 1'b0;
      word_ready_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      wbit_q       <= wbit_d;
      rb_cnt_q     <= rb_cnt_d;
      word_sr_q    <= word_sr_d;
      rb_sr_q      <= rb_sr_d;
      rb_data_q    <= rb_data_d;
      rb_valid_q   <= rb_valid_d;
      cfg_shift_q  <= cfg_shift_d;
      cfg_cen_q    <= cfg_cen_d;
      cfg_set_q    <= cfg_set_d;
      word_ready_q <= word_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign word_ready = word_ready_q;
  assign cfg_shift  = cfg_shift_q;
  assign cfg_cen    = cfg_cen_q;
  assign cfg_set    = cfg_set_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign rb_valid   = rb_valid_q;
  assign rb_data    = rb_data_q;

endmodule

`default_nettype wire

// File: tb/tb_fabric_config_loader.sv
// tb_fabric_config_loader: two loaders (8-bit and 6-bit chains) looped back through
// behavioural chain models, checked against a transaction-level expectation per load.
`default_nettype none

module tb_fabric_config_loader;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_v [2];
  logic wv_v    [2];
  logic ready_v [2];
  logic shift_v [2];
  logic cen_v   [2];
  logic set_v   [2];
  logic busy_v  [2];
  logic done_v  [2];
  logic rbv_v   [2];
  logic tail_v  [2];
  logic [W-1:0] wd_v  [2];
  logic [W-1:0] rbd_v [2];
  logic [7:0]   chain [2] = '{8'h00, 8'h00};

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  int ncen [2], nacc [2], nrb [2], nset [2], ndone [2];
  int st_cyc [2], done_cyc [2], rb_at_set [2];
  int hold_err [2], rb_err [2], excl_err [2];
  logic         shlog [2][32];
  logic [W-1:0] rblog [2][4];
  logic         prev_shift [2];
  logic [W-1:0] last_rbd [2];

  always #5 clk = ~clk;

  generate
    for (genvar g = 0; g < 2; g++) begin : g_dut
      fabric_config_loader #(.WORD_W(W), .CHAIN_LEN(g == 0 ? 8 : 6)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start_v[g]),
        .word_valid (wv_v[g]),
        .word_data  (wd_v[g]),
        .word_ready (ready_v[g]),
        .cfg_shift  (shift_v[g]),
        .cfg_cen    (cen_v[g]),
        .cfg_set    (set_v[g]),
        .cfg_tail   (tail_v[g]),
        .busy       (busy_v[g]),
        .done       (done_v[g]),
        .rb_valid   (rbv_v[g]),
        .rb_data    (rbd_v[g])
      );
    end
  endgenerate

  // Chain models: head at bit 0, tail at bit CHAIN_LEN-1.
  assign tail_v[0] = chain[0][7];
  assign tail_v[1] = chain[1][5];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++)
      if (cen_v[i] === 1'b1) chain[i] <= {chain[i][6:0], shift_v[i]};
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Observation of both loaders, sampled mid-cycle.
  initial begin
    for (int i = 0; i < 2; i++) begin
      ncen[i] = 0; nacc[i] = 0; nrb[i] = 0; nset[i] = 0; ndone[i] = 0;
      st_cyc[i] = 0; done_cyc[i] = 0; rb_at_set[i] = 0;
      hold_err[i] = 0; rb_err[i] = 0; excl_err[i] = 0;
      prev_shift[i] = 1'b0; last_rbd[i] = '0;
    end
    forever begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < 2; i++) begin
        if (rst) begin
          prev_shift[i] = 1'b0;
          last_rbd[i]   = '0;
        end else begin
          if (start_v[i] && !busy_v[i]) begin
            st_cyc[i] = cyc;
            ncen[i] = 0; nacc[i] = 0; nrb[i] = 0; nset[i] = 0; ndone[i] = 0;
            rb_at_set[i] = -1; hold_err[i] = 0; rb_err[i] = 0; excl_err[i] = 0;
          end
          if (cen_v[i]) begin
            if (ncen[i] < 32) shlog[i][ncen[i]] = shift_v[i];
            ncen[i]++;
          end else if (shift_v[i] !== prev_shift[i]) begin
            hold_err[i]++;
          end
          prev_shift[i] = shift_v[i];
          if (ready_v[i] && wv_v[i]) nacc[i]++;
          if (ready_v[i] && cen_v[i]) excl_err[i]++;
          if (rbv_v[i]) begin
            if (nrb[i] < 4) rblog[i][nrb[i]] = rbd_v[i];
            nrb[i]++;
            last_rbd[i] = rbd_v[i];
          end else if (rbd_v[i] !== last_rbd[i]) begin
            rb_err[i]++;
          end
          if (set_v[i]) begin
            nset[i]++;
            rb_at_set[i] = nrb[i];
          end
          if (done_v[i]) begin
            ndone[i]++;
            done_cyc[i] = cyc;
          end
        end
      end
    end
  end

  // One complete load on loader i; entered and left just after a rising edge.
  task automatic do_load(input int i, input logic [W-1:0] wds [4], input int stl [4],
                         input bit dbl, input string tag);
    int L, nw, tot, guard, idx;
    logic [7:0]   cs, eb, gb;
    logic [W-1:0] er;
    L   = (i == 0) ? 8 : 6;
    nw  = (L + W - 1) / W;
    cs  = chain[i];
    tot = 0;
    for (int w = 0; w < nw; w++) tot += stl[w];

    start_v[i] = 1'b1;
    if (stl[0] == 0) begin
      wv_v[i] = 1'b1;
      wd_v[i] = wds[0];
    end
    @(posedge clk) #1;
    start_v[i] = 1'b0;

    for (int w = 0; w < nw; w++) begin
      if (stl[w] > 0) begin
        wv_v[i] = 1'b0;
        guard = 0;
        do begin @(negedge clk); guard++; end while (!ready_v[i] && guard < 100);
        repeat (stl[w] - 1) @(negedge clk);
        @(posedge clk) #1;
        wv_v[i] = 1'b1;
        wd_v[i] = wds[w];
      end
      guard = 0;
      do begin @(negedge clk); guard++; end while (!(ready_v[i] && wv_v[i]) && guard < 100);
      chk({tag, " accept"}, 32'(guard < 100), 32'd1);
      @(posedge clk) #1;
      if (w + 1 < nw && stl[w+1] == 0) begin
        wv_v[i] = 1'b1;
        wd_v[i] = wds[w+1];
      end else begin
        wv_v[i] = 1'b0;
      end
      if (dbl && w == 0) begin
        start_v[i] = 1'b1;
        @(posedge clk) #1;
        start_v[i] = 1'b0;
      end
    end
    wv_v[i] = 1'b0;

    guard = 0;
    do begin @(negedge clk); guard++; end while (!done_v[i] && guard < 200);
    chk({tag, " done seen"}, 32'(guard < 200), 32'd1);
    repeat (3) @(negedge clk);

    eb = '0;
    gb = '0;
    for (int b = 0; b < L; b++) begin
      eb[b] = wds[b / W][b % W];
      gb[b] = shlog[i][b];
    end
    chk({tag, " shift bits"}, 32'(gb), 32'(eb));
    chk({tag, " cen cycles"}, 32'(ncen[i]), 32'(L));
    chk({tag, " words taken"}, 32'(nacc[i]), 32'(nw));
    chk({tag, " set pulses"}, 32'(nset[i]), 32'd1);
    chk({tag, " done pulses"}, 32'(ndone[i]), 32'd1);
    chk({tag, " latency"}, 32'(done_cyc[i] - st_cyc[i]), 32'(nw + L + 2 + tot));
    chk({tag, " rb pulses"}, 32'(nrb[i]), 32'(nw));
    for (int k = 0; k < nw; k++) begin
      for (int j = 0; j < W; j++) begin
        idx   = k * W + j;
        er[j] = (idx < L) ? cs[L - 1 - idx] : 1'b0;
      end
      chk({tag, " rb word"}, 32'(rblog[i][k]), 32'(er));
    end
    chk({tag, " rb before set"}, 32'(rb_at_set[i]), 32'(nw));
    chk({tag, " shift hold"}, 32'(hold_err[i]), 32'd0);
    chk({tag, " rb stable"}, 32'(rb_err[i]), 32'd0);
    chk({tag, " ready/cen overlap"}, 32'(excl_err[i]), 32'd0);
    @(posedge clk) #1;
  endtask

  logic [W-1:0] wa [4];
  int           sa [4];
  int           guard_m;

  initial begin
    for (int i = 0; i < 2; i++) begin
      start_v[i] = 1'b0;
      wv_v[i]    = 1'b0;
      wd_v[i]    = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++)
      chk("reset outputs", 32'({ready_v[i], shift_v[i], cen_v[i], set_v[i], busy_v[i],
                                done_v[i], rbv_v[i], rbd_v[i]}), 32'd0);
    @(posedge clk) #1;
    rst = 1'b0;

    // Start in the very first cycle after reset release.
    wa = '{4'hA, 4'h5, 4'h0, 4'h0};
    sa = '{0, 0, 0, 0};
    do_load(0, wa, sa, 1'b0, "basic");

    wa = '{4'hF, 4'h3, 4'h0, 4'h0};
    do_load(1, wa, sa, 1'b0, "partial");

    wa = '{4'hA, 4'h5, 4'h0, 4'h0};
    sa = '{0, 5, 0, 0};
    do_load(0, wa, sa, 1'b0, "stall");

    wa = '{4'h3, 4'hC, 4'h0, 4'h0};
    sa = '{0, 0, 0, 0};
    do_load(0, wa, sa, 1'b0, "preload");
    wa = '{W'($urandom_range(0, 15)), W'($urandom_range(0, 15)), 4'h0, 4'h0};
    do_load(0, wa, sa, 1'b0, "loopback");
    chk("loopback rb0", 32'(rblog[0][0]), 32'h3);
    chk("loopback rb1", 32'(rblog[0][1]), 32'hC);

    wa = '{W'($urandom_range(0, 15)), W'($urandom_range(0, 15)), 4'h0, 4'h0};
    do_load(0, wa, sa, 1'b1, "busy start");

    // Reset during the third shift cycle.
    start_v[0] = 1'b1;
    wv_v[0]    = 1'b1;
    wd_v[0]    = W'($urandom_range(0, 15));
    @(posedge clk) #1;
    start_v[0] = 1'b0;
    guard_m = 0;
    while (ncen[0] != 2 && guard_m < 50) begin
      @(posedge clk) #1;
      wv_v[0] = 1'b0;
      guard_m++;
    end
    chk("midload reach shift3", 32'(guard_m < 50), 32'd1);
    rst = 1'b1;
    @(posedge clk) #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midload reset outputs", 32'({ready_v[0], shift_v[0], cen_v[0], set_v[0], busy_v[0],
                                      done_v[0], rbv_v[0], rbd_v[0]}), 32'd0);
    repeat (20) @(negedge clk);
    chk("midload no set", 32'(nset[0]), 32'd0);
    @(posedge clk) #1;
    wa = '{W'($urandom_range(0, 15)), W'($urandom_range(0, 15)), 4'h0, 4'h0};
    do_load(0, wa, sa, 1'b0, "after reset");

    for (int k = 0; k < 8; k++) begin
      for (int w = 0; w < 4; w++) begin
        wa[w] = W'($urandom_range(0, 15));
        sa[w] = $urandom_range(0, 3);
      end
      do_load(k % 2, wa, sa, 1'($urandom_range(0, 1)), "random");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
